// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle for serial_adder_ctrl.
// The overflow signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int NUM_BITS = 8
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic                overflow;
`endif

  modport master (
    output start, a, b, carry_in,
`ifdef SERIAL_ADDER_OVF_EN
    input  overflow,
`endif
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
`ifdef SERIAL_ADDER_OVF_EN
    output overflow,
`endif
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial NUM_BITS-wide adder: one full-adder slice sequenced LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_reg;
  logic [NUM_BITS-1:0] a_sr_reg;
  logic [NUM_BITS-1:0] b_sr_reg;
  logic [NUM_BITS-1:0] res_sr_reg;
  logic                c_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [NUM_BITS-1:0] sum_reg;
  logic                carry_out_reg;
  logic                slice_sum;
  logic                slice_carry;

  adder_1bit u_slice (
    .a         (a_sr_reg[0]),
    .b         (b_sr_reg[0]),
    .carry_in  (c_reg),
    .sum       (slice_sum),
    .carry_out (slice_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      res_sr_reg    <= '0;
      c_reg         <= 1'b0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      // done trails the DONE state by one edge, so it coincides with the
      // freshly published sum/carry_out.
      done_reg <= (state_reg == ST_DONE);
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr_reg   <= bus.a;
            b_sr_reg   <= bus.b;
            c_reg      <= bus.carry_in;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_ADD;
          end
        end
        ST_ADD: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          res_sr_reg <= {slice_sum, res_sr_reg[NUM_BITS-1:1]};
          c_reg      <= slice_carry;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BIT) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          sum_reg       <= res_sr_reg;
          carry_out_reg <= c_reg;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;
  logic overflow_reg;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (state_reg == ST_ADD && cnt_reg == LAST_BIT) begin
        ovf_reg <= c_reg ^ slice_carry;
      end
      if (state_reg == ST_DONE) begin
        overflow_reg <= ovf_reg;
      end
    end
  end

  assign bus.overflow = overflow_reg;
`endif

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.sum       = sum_reg;
  assign bus.carry_out = carry_out_reg;
endmodule
